// File: rtl/vga_timing_gen_pkg.sv
// Shared timing defaults, counter widths and colour types for the VGA raster generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_gen_pkg;

   // 640x480@60 defaults
   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int CW_DEF       = 8;

   // Counter widths: H_TOTAL <= 4095, V_TOTAL <= 2047
   localparam int H_CNT_W = 12;
   localparam int V_CNT_W = 11;

   typedef struct packed {
      logic [CW_DEF-1:0] r;
      logic [CW_DEF-1:0] g;
      logic [CW_DEF-1:0] b;
   } colour_t;

   typedef enum logic [1:0] {
      PAT_PASS  = 2'd0,
      PAT_BARS  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_WHITE = 2'd3
   } pattern_e;

   // Colour-bar index 0..7 across the visible width
   function automatic logic [2:0] bar_index(input logic [H_CNT_W-1:0] x, input int active);
      return 3'((int'(x) * 8) / active);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch and video-output bundle of the VGA raster generator.
// Latency: pix_rgb returns exactly 1 clk after pix_req; video outputs lag the fetch request by 2 clk.
// Backpressure: none; the frame source must answer every request on time.
// Ports: pix_req/pix_x/pix_y (request), pix_rgb (return), hsync/vsync/de/red/green/blue, frame_start/line_start.
interface vga_timing_gen_if #(
   parameter int CW = 8
);
   logic            pix_req;
   logic [11:0]     pix_x;
   logic [10:0]     pix_y;
   logic [3*CW-1:0] pix_rgb;
   logic            hsync;
   logic            vsync;
   logic            de;
   logic [CW-1:0]   red;
   logic [CW-1:0]   green;
   logic [CW-1:0]   blue;
   logic            frame_start;
   logic            line_start;

   // master = timing generator, slave = frame source / display sink
   modport master (
      output pix_req, pix_x, pix_y, hsync, vsync, de, red, green, blue, frame_start, line_start,
      input  pix_rgb
   );
   modport slave (
      input  pix_req, pix_x, pix_y, hsync, vsync, de, red, green, blue, frame_start, line_start,
      output pix_rgb
   );
endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: wrapping position counter with active-area and raw sync-window decode.
// Latency: decodes are combinational from the registered count.
// Backpressure: count holds whenever en_i or inc_i is low.
// Ports: clk, rst_n, en_i, inc_i (step request), cnt_o, wrap_o (stepping past last), active_o, sync_o.
module vga_timing_gen_axis_counter #(
   parameter int W      = 12,
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o,
   output logic         active_o,
   output logic         sync_o
);
   localparam int TOTAL = ACTIVE + FP + SYNC + BP;
   localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
   localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
   localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
   localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

   if (TOTAL > (1 << W) - 1 || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_cfg
      $error("vga_timing_gen_axis_counter: timing parameter zero or total exceeds counter width");
   end

   logic [W-1:0] cnt_q, cnt_d;
   logic         step;

   assign step = en_i && inc_i;

   always_comb begin
      cnt_d = cnt_q;
      if (step) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt_o    = cnt_q;
   assign wrap_o   = inc_i && (cnt_q == LAST);
   assign active_o = cnt_q < ACT_END;
   assign sync_o   = (cnt_q >= SYNC_BEG) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, pixel fetch request, 2-clk aligned sync/de/RGB output.
// Latency: counter position -> hsync/vsync/de/rgb/strobes = 2 clk; pix_rgb is taken 1 clk after pix_req.
// Backpressure: en=0 freezes counters and pipeline, withdraws pix_req and blanks outputs; resumes in place.
// Ports: clk, rst_n (async active-low), en, pattern_sel, vif (master modport of vga_timing_gen_if).
// Build option VGA_TEST_PATTERN_EN: replaces fetched colour with a pattern chosen by pattern_sel.
module vga_timing_gen
   import vga_timing_gen_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CW       = CW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       pattern_sel,
   vga_timing_gen_if.master vif
);
   logic [H_CNT_W-1:0] h_cnt;
   logic [V_CNT_W-1:0] v_cnt;
   logic h_wrap, h_act, h_sync, v_act, v_sync, unused_v_wrap;
   logic active;

   vga_timing_gen_axis_counter #(
      .W(H_CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
   ) u_h_cnt (
      .clk(clk), .rst_n(rst_n), .en_i(en), .inc_i(1'b1),
      .cnt_o(h_cnt), .wrap_o(h_wrap), .active_o(h_act), .sync_o(h_sync)
   );

   vga_timing_gen_axis_counter #(
      .W(V_CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
   ) u_v_cnt (
      .clk(clk), .rst_n(rst_n), .en_i(en), .inc_i(h_wrap),
      .cnt_o(v_cnt), .wrap_o(unused_v_wrap), .active_o(v_act), .sync_o(v_sync)
   );

   // Stage 0: fetch request straight from the counters
   assign active      = h_act && v_act;
   assign vif.pix_req = active && en;
   assign vif.pix_x   = active ? h_cnt : '0;
   assign vif.pix_y   = active ? v_cnt : '0;

   // Stage 1 state
   logic act1_q, hs1_q, vs1_q, fs1_q, ls1_q;
   // Returned data arrives even if en drops right after the request; it is
   // parked in hold_q so the frozen pipeline still has it when en returns.
   logic            req1_q;
   logic [3*CW-1:0] hold_q, rgb_src, colour_d;
   // Stage 2 (output) state
   logic de_q, hs_q, vs_q, fs_q, ls_q;
   logic [3*CW-1:0] rgb_q;

   assign rgb_src = req1_q ? vif.pix_rgb : hold_q;

`ifdef VGA_TEST_PATTERN_EN
   logic [H_CNT_W-1:0] x1_q;
   logic [V_CNT_W-1:0] y1_q;
   logic [2:0]         bar;

   always_comb begin
      bar      = bar_index(x1_q, H_ACTIVE);
      colour_d = rgb_src;
      case (pattern_e'(pattern_sel))
         PAT_BARS:  colour_d = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
         PAT_CHECK: colour_d = (x1_q[3] ^ y1_q[3]) ? '1 : '0;
         PAT_WHITE: colour_d = '1;
         default:   colour_d = rgb_src;
      endcase
   end
`else
   logic unused_pattern;
   assign unused_pattern = ^pattern_sel;
   assign colour_d       = rgb_src;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req1_q <= 1'b0;
         hold_q <= '0;
         act1_q <= 1'b0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
         fs1_q  <= 1'b0;
         ls1_q  <= 1'b0;
         de_q   <= 1'b0;
         hs_q   <= ~H_POL;
         vs_q   <= ~V_POL;
         fs_q   <= 1'b0;
         ls_q   <= 1'b0;
         rgb_q  <= '0;
`ifdef VGA_TEST_PATTERN_EN
         x1_q   <= '0;
         y1_q   <= '0;
`endif
      end else begin
         req1_q <= vif.pix_req;
         if (req1_q) hold_q <= vif.pix_rgb;
         if (en) begin
            act1_q <= active;
            hs1_q  <= h_sync;
            vs1_q  <= v_sync;
            fs1_q  <= active && (h_cnt == '0) && (v_cnt == '0);
            ls1_q  <= active && (h_cnt == '0);
            de_q   <= act1_q;
            hs_q   <= hs1_q ? H_POL : ~H_POL;
            vs_q   <= vs1_q ? V_POL : ~V_POL;
            fs_q   <= fs1_q;
            ls_q   <= ls1_q;
            rgb_q  <= act1_q ? colour_d : '0;
`ifdef VGA_TEST_PATTERN_EN
            x1_q   <= h_cnt;
            y1_q   <= v_cnt;
`endif
         end
      end
   end

   // While paused the frozen output stage is masked, not overwritten, so
   // nothing is lost when the raster resumes.
   assign vif.de          = en && de_q;
   assign vif.hsync       = en ? hs_q : ~H_POL;
   assign vif.vsync       = en ? vs_q : ~V_POL;
   assign vif.frame_start = en && fs_q;
   assign vif.line_start  = en && ls_q;
   assign vif.red         = en ? rgb_q[3*CW-1 -: CW] : '0;
   assign vif.green       = en ? rgb_q[2*CW-1 -: CW] : '0;
   assign vif.blue        = en ? rgb_q[CW-1 -: CW]   : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 raster (H 8/2/3/1, V 4/1/2/1, active-low syncs).
// Latency: the frame source model answers every pix_req one clock later.
// Backpressure: en is toggled mid-line to pause the raster.
module tb_vga_timing_gen;
   localparam int CW = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] pattern_sel = 2'd0;

   vga_timing_gen_if #(.CW(CW)) vif();

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .CW(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .pattern_sel(pattern_sel), .vif(vif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [23:0] pix_val(input logic [11:0] x, input logic [10:0] y);
      return {8'h40 + x[7:0], 8'h80 + y[7:0], y[3:0], x[3:0]};
   endfunction

   // Frame source: request seen at a rising edge is answered from the next
   // falling edge, so the data is stable at the following rising edge.
   logic        cap_req = 1'b0;
   logic [11:0] cap_x = '0;
   logic [10:0] cap_y = '0;
   always @(posedge clk) begin
      cap_req = vif.pix_req;
      cap_x   = vif.pix_x;
      cap_y   = vif.pix_y;
   end
   always @(negedge clk) vif.pix_rgb = cap_req ? pix_val(cap_x, cap_y) : 24'hDEAD5A;

   task automatic release_and_check(input string tag);
      @(negedge clk); rst_n = 1'b1; #1;
      checks++;
      if (vif.pix_req !== 1'b1 || vif.pix_x !== 12'd0 || vif.pix_y !== 11'd0) begin
         errors++; $display("FAIL %s_cycle0_req: req=%b x=%0d y=%0d need req=1 x=0 y=0", tag, vif.pix_req, vif.pix_x, vif.pix_y);
      end
      checks++;
      if (vif.de !== 1'b0) begin errors++; $display("FAIL %s_cycle0_de: de=%b need 0", tag, vif.de); end
      @(negedge clk); #1;
      checks++;
      if (vif.de !== 1'b0 || vif.pix_x !== 12'd1) begin
         errors++; $display("FAIL %s_cycle1: de=%b x=%0d need de=0 x=1", tag, vif.de, vif.pix_x);
      end
      @(negedge clk); #1;
      checks++;
      if (vif.de !== 1'b1 || vif.frame_start !== 1'b1 || vif.line_start !== 1'b1) begin
         errors++; $display("FAIL %s_cycle2_strobes: de=%b fs=%b ls=%b need 1 1 1", tag, vif.de, vif.frame_start, vif.line_start);
      end
      checks++;
      if ({vif.red, vif.green, vif.blue} !== pix_val(12'd0, 11'd0)) begin
         errors++; $display("FAIL %s_cycle2_rgb: got %h need %h", tag, {vif.red, vif.green, vif.blue}, pix_val(12'd0, 11'd0));
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (vif.pix_req !== 1'b0) begin errors++; $display("FAIL reset_req_en0: req=%b need 0", vif.pix_req); end
      en = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
         errors++; $display("FAIL reset_sync: hs=%b vs=%b need 1 1", vif.hsync, vif.vsync);
      end
      checks++;
      if (vif.de !== 1'b0 || {vif.red, vif.green, vif.blue} !== 24'h0) begin
         errors++; $display("FAIL reset_video: de=%b rgb=%h need 0 0", vif.de, {vif.red, vif.green, vif.blue});
      end
      checks++;
      if (vif.frame_start !== 1'b0 || vif.line_start !== 1'b0) begin
         errors++; $display("FAIL reset_strobes: fs=%b ls=%b need 0 0", vif.frame_start, vif.line_start);
      end
      release_and_check("reset");
   endtask

   // Starts on a sampled frame_start cycle and ends on the next one.
   // Only en=1 cycles advance the raster, so the counts are over those cycles.
   task automatic measure_frame(input string tag, input bit do_pause);
      int clks = 0, des = 0, vs_low = 0, hs_low = 0, hs_first = -1, ls_cnt = 0;
      int off_left = 0, ex = 0, ey = 0;
      bit paused = 0, resumed = 0, done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         if (i > 0) begin
            @(negedge clk);
            resumed = 0;
            if (!en) begin
               off_left--;
               if (off_left == 0) begin en = 1'b1; resumed = 1; end
            end else if (do_pause && !paused && vif.pix_req && vif.pix_x == 12'd4 && vif.pix_y == 11'd1) begin
               en = 1'b0; off_left = 5; paused = 1;
            end
            #1;
         end
         if (en && i > 0 && vif.frame_start === 1'b1) begin
            done = 1;
         end else if (en) begin
            clks++;
            checks++;
            if (vif.line_start !== (vif.de && ex == 0)) begin
               errors++; $display("FAIL %s_line_start: ls=%b de=%b ex=%0d", tag, vif.line_start, vif.de, ex);
            end
            checks++;
            if (vif.de === 1'b1) begin
               if ({vif.red, vif.green, vif.blue} !== pix_val(12'(ex), 11'(ey))) begin
                  errors++; $display("FAIL %s_rgb: pixel (%0d,%0d) got %h need %h", tag, ex, ey, {vif.red, vif.green, vif.blue}, pix_val(12'(ex), 11'(ey)));
               end
               des++;
               if (vif.line_start === 1'b1) ls_cnt++;
               ex++;
               if (ex == 8) begin ex = 0; ey++; end
            end else if ({vif.red, vif.green, vif.blue} !== 24'h0) begin
               errors++; $display("FAIL %s_rgb_blank: got %h need 0", tag, {vif.red, vif.green, vif.blue});
            end
            if (vif.vsync === 1'b0) vs_low++;
            if (vif.hsync === 1'b0) begin
               hs_low++;
               if (hs_first < 0) hs_first = clks - 1;
            end
         end else begin
            checks++;
            if (vif.de !== 1'b0 || {vif.red, vif.green, vif.blue} !== 24'h0) begin
               errors++; $display("FAIL %s_pause_video: de=%b rgb=%h need 0 0", tag, vif.de, {vif.red, vif.green, vif.blue});
            end
            checks++;
            if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
               errors++; $display("FAIL %s_pause_sync: hs=%b vs=%b need 1 1", tag, vif.hsync, vif.vsync);
            end
            checks++;
            if (vif.pix_req !== 1'b0 || vif.frame_start !== 1'b0 || vif.line_start !== 1'b0) begin
               errors++; $display("FAIL %s_pause_req: req=%b fs=%b ls=%b need 0 0 0", tag, vif.pix_req, vif.frame_start, vif.line_start);
            end
         end
         if (resumed) begin
            checks++;
            if (vif.pix_req !== 1'b1 || vif.pix_x !== 12'd4 || vif.pix_y !== 11'd1) begin
               errors++; $display("FAIL %s_resume_req: req=%b x=%0d y=%0d need 1 4 1", tag, vif.pix_req, vif.pix_x, vif.pix_y);
            end
         end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL %s_timeout: no second frame_start, got 0 need 1", tag); end
      checks++;
      if (clks != 112) begin errors++; $display("FAIL %s_frame_clks: got %0d need 112", tag, clks); end
      checks++;
      if (des != 32) begin errors++; $display("FAIL %s_de_count: got %0d need 32", tag, des); end
      checks++;
      if (vs_low != 28) begin errors++; $display("FAIL %s_vsync_low: got %0d need 28", tag, vs_low); end
      checks++;
      if (hs_low != 24) begin errors++; $display("FAIL %s_hsync_low: got %0d need 24", tag, hs_low); end
      checks++;
      if (hs_first != 10) begin errors++; $display("FAIL %s_hsync_offset: got %0d need 10", tag, hs_first); end
      checks++;
      if (ls_cnt != 4) begin errors++; $display("FAIL %s_line_starts: got %0d need 4", tag, ls_cnt); end
      if (do_pause) begin
         checks++;
         if (!paused) begin errors++; $display("FAIL %s_pause_hit: got 0 need 1", tag); end
      end
   endtask

   task automatic test_frame_wrap();
      bit found = 0, found2 = 0, prev_req = 1;
      int n = 0, reqs = 0;
      logic [11:0] last_x = '0;
      logic [10:0] last_y = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (vif.pix_req === 1'b1 && vif.pix_x === 12'd0 && vif.pix_y === 11'd0) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL wrap_find_origin: got 0 need 1"); end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         n++;
         if (vif.pix_req === 1'b1 && vif.pix_x === 12'd0 && vif.pix_y === 11'd0) begin found2 = 1; break; end
         prev_req = vif.pix_req;
         if (vif.pix_req === 1'b1) begin reqs++; last_x = vif.pix_x; last_y = vif.pix_y; end
      end
      checks++;
      if (!found2 || n != 112) begin errors++; $display("FAIL wrap_period: found=%b clks=%0d need 1 112", found2, n); end
      checks++;
      if (reqs != 31 || prev_req !== 1'b0) begin
         errors++; $display("FAIL wrap_reqs: reqs=%0d prev_req=%b need 31 0", reqs, prev_req);
      end
      checks++;
      if (last_x !== 12'd7 || last_y !== 11'd3) begin
         errors++; $display("FAIL wrap_last_pixel: got (%0d,%0d) need (7,3)", last_x, last_y);
      end
   endtask

   task automatic test_async_reset();
      bit found = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk); #1;
         if (vif.hsync === 1'b0 && vif.vsync === 1'b0) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL arst_find_sync: got 0 need 1"); end
      #2; rst_n = 1'b0; #1;   // still well before the next rising edge
      checks++;
      if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin
         errors++; $display("FAIL arst_sync: hs=%b vs=%b need 1 1", vif.hsync, vif.vsync);
      end
      checks++;
      if (vif.de !== 1'b0 || {vif.red, vif.green, vif.blue} !== 24'h0) begin
         errors++; $display("FAIL arst_video: de=%b rgb=%h need 0 0", vif.de, {vif.red, vif.green, vif.blue});
      end
      release_and_check("arst");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      measure_frame("frame", 1'b0);
      measure_frame("pause", 1'b1);
      test_frame_wrap();
      test_async_reset();
      measure_frame("after_arst", 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
